// File: rtl/idma_req_rr_sched.sv
// Round-robin scheduler sharing one 1D legalizer among NumReq requesters, with an in-order ID FIFO routing completions back.
// Request path is combinational (zero latency); done_o pulses one cycle after done_i; issue stalls while the ID FIFO is full.
module idma_req_rr_sched #(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned ReqWidth = 64,
    parameter int unsigned IdDepth  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0][ReqWidth-1:0] req_i,
    input  logic [NumReq-1:0]               valid_i,
    output logic [NumReq-1:0]               ready_o,
    output logic [ReqWidth-1:0]             req_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    input  logic                            done_i,
    output logic [NumReq-1:0]               done_o,
    output logic [$clog2(IdDepth):0]        outstanding_o,
    output logic                            busy_o,
    output logic                            err_o
);
    localparam int unsigned PtrW = $clog2(NumReq);
    localparam int unsigned IdW  = $clog2(IdDepth);
    localparam int unsigned CntW = IdW + 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   ptr_q, lock_idx_q, arb_idx, scan_idx, grant;
    logic              found;
    logic [PtrW-1:0]   id_mem_q [IdDepth];
    logic [IdW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   cnt_q;
    logic [NumReq-1:0] done_q;
    logic              err_q;
    logic              full, push, pop;

    // First valid requester at or after ptr_q, wrapping modulo NumReq.
    always_comb begin
        arb_idx  = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        for (int i = 0; i < int'(NumReq); i++) begin
            scan_idx = PtrW'((int'(ptr_q) + i) % int'(NumReq));
            if (!found && valid_i[scan_idx]) begin
                found   = 1'b1;
                arb_idx = scan_idx;
            end
        end
    end

    assign grant = (state_q == LOCKED) ? lock_idx_q : arb_idx;
    assign full  = (cnt_q == CntW'(IdDepth));

    assign req_o   = req_i[grant];
    assign valid_o = !rst_i && valid_i[grant] && !full;

    always_comb begin
        ready_o = '0;
        if (!rst_i && !full && ready_i) begin
            ready_o[grant] = 1'b1;
        end
    end

    assign push = valid_o && ready_i;
    assign pop  = done_i && (cnt_q != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_o && !ready_i) state_d = LOCKED;
            LOCKED:  if (push) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == LOCKED) begin
                lock_idx_q <= arb_idx;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                ptr_q    <= (grant == PtrW'(NumReq - 1)) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q  <= cnt_q + CntW'(push) - CntW'(pop);
            done_q <= '0;
            if (pop) begin
                done_q[id_mem_q[rd_ptr_q]] <= 1'b1;
            end
            // A completion with nothing outstanding means the legalizer and this block disagree.
            if (done_i && cnt_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= grant;
        end
    end

    assign done_o        = rst_i ? '0 : done_q;
    assign err_o         = err_q && !rst_i;
    assign outstanding_o = rst_i ? '0 : cnt_q;
    assign busy_o        = !rst_i && ((cnt_q != '0) || valid_o);

endmodule

// File: doc/idma_req_rr_sched.md
IDMA_REQ_RR_SCHED -- requirements
Module: idma_req_rr_sched

Interface
REQ-001 Parameter NumReq, default 4, number of requesters feeding the shared legalizer; legal range 2..16.
REQ-002 Parameter ReqWidth, default 64, width in bits of the packed 1D request payload.
REQ-003 Parameter IdDepth, default 8, depth of the in-order completion-ID FIFO; power of two, at least 2.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous and active-high.
REQ-006 req_i  input  NumReq x ReqWidth  per-requester 1D request payload.
REQ-007 valid_i  input  NumReq  per-requester request valid.
REQ-008 ready_o  output  NumReq  per-requester request ready; at most one bit high.
REQ-009 req_o  output  ReqWidth  granted payload toward the legalizer.
REQ-010 valid_o  output  1  granted request valid.
REQ-011 ready_i  input  1  legalizer ready.
REQ-012 done_i  input  1  one-cycle pulse per completed 1D transfer; completions arrive in issue order.
REQ-013 done_o  output  NumReq  one-hot, one-cycle completion pulse routed to the originating requester.
REQ-014 outstanding_o  output  clog2(IdDepth)+1  number of issued, not-yet-completed transfers.
REQ-015 busy_o  output  1  high when outstanding_o is nonzero or valid_o is high.
REQ-016 err_o  output  1  sticky flag; set when done_i arrives while outstanding_o is 0.

Function
REQ-017 Arbitration: round-robin; search starts at priority pointer ptr_q and wraps modulo NumReq; the first index with valid_i high wins.
REQ-018 Lock: while valid_o=1 and ready_i=0, the grant index is held in a register, and req_o/valid_o follow that requester only; no re-arbitration occurs even if a higher-priority valid rises.
REQ-019 Requesters shall hold valid_i and req_i stable until handshake; the block does not buffer payloads.
REQ-020 Datapath is combinational: req_o equals req_i[grant], valid_o equals valid_i[grant] AND NOT fifo_full, and ready_o[grant] equals ready_i AND NOT fifo_full; zero-cycle latency.
REQ-021 Handshake (valid_o AND ready_i) pushes the grant index into the ID FIFO, releases the lock, and sets ptr_q to grant+1 modulo NumReq on the next edge.
REQ-022 FIFO full (outstanding = IdDepth): valid_o=0 and all ready_o=0, even if done_i pops in the same cycle; issue resumes the cycle after the count drops.
REQ-023 done_i with FIFO non-empty pops the head index; done_o[head] pulses on the next cycle (registered, 1-cycle latency).
REQ-024 Simultaneous push and pop when not full: outstanding is unchanged, the FIFO order is preserved, and the pop returns the older entry.
REQ-025 done_i with FIFO empty: no pop, done_o stays 0, err_o is set to 1 and stays high until reset.
REQ-026 Lock state machine: IDLE (no lock) goes to LOCKED on valid_o AND NOT ready_i; LOCKED goes to IDLE on handshake; IDLE stays IDLE on an immediate handshake.
REQ-027 Pointer and FIFO indices are log2-width counters that wrap naturally; the outstanding count saturates neither above IdDepth nor below 0 by construction.

Reset
REQ-028 While rst_i=1: ptr_q=0, lock state IDLE, FIFO empty, outstanding_o=0, done_o=0, err_o=0, busy_o=0.
REQ-029 While rst_i=1: valid_o=0 and all ready_o=0 regardless of inputs.
REQ-030 Reset asserted mid-operation discards all outstanding IDs; a done_i arriving after reset with an empty FIFO sets err_o per REQ-025.
REQ-031 First arbitration after reset starts at index 0.

Verification
REQ-032 All four valid_i high, ready_i=1 for 4 cycles -> grants 0,1,2,3 in order; outstanding_o=4; then 4 done_i pulses give done_o=0001,0010,0100,1000 one cycle after each pulse.
REQ-033 valid_i[2]=1, ready_i=0 for 3 cycles, then valid_i[0] rises -> grant stays 2 (LOCKED); ready_i=1 -> handshake on 2, and the next grant is 0 only via the wrap from ptr=3.
REQ-034 IdDepth=8, 8 handshakes with no done_i -> outstanding_o=8, valid_o=0, ready_o=0; done_i pulse plus valid in the same cycle -> no issue that cycle, issue on the next.
REQ-035 outstanding_o=3, one push and one done_i in the same cycle -> outstanding_o stays 3; done_o targets the oldest requester.
REQ-036 done_i with outstanding_o=0 -> err_o=1, done_o=0; err_o remains 1 until rst_i pulse, then 0.
REQ-037 rst_i asserted with 5 outstanding -> next cycle outstanding_o=0, busy_o=0, ptr_q=0.
